key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the number of independent input channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), giving the consecutive stable cycles required to accept a change; legal range 2 to 2^24.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1, where 1 means the raw input reads 0 while pressed.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock; all state is clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-006 The block SHALL have port key_in, input, WIDTH bits, raw asynchronous key or switch levels.
REQ-007 The block SHALL have port pressed, output, WIDTH bits, the debounced level; 1 means pressed, regardless of ACTIVE_LOW.
REQ-008 The block SHALL have port press, output, WIDTH bits, a one-cycle pulse on an accepted press.
REQ-009 The block SHALL have port release, output, WIDTH bits, a one-cycle pulse on an accepted release.
REQ-010 The block SHALL have port toggle, output, WIDTH bits, a level that inverts on every accepted press.

Function
REQ-011 Each channel SHALL be fully independent, with its own synchronizer, counter, state and outputs.
REQ-012 Each channel SHALL pass key_in through a 2-flop synchronizer; only the second flop output (sync) is used downstream.
REQ-013 Each channel SHALL hold a debounced raw level db, and SHALL derive pressed = db XOR ACTIVE_LOW.
REQ-014 Each channel SHALL run a 2-state FSM: STABLE (sync == db) and CHECK (sync != db, counting).
REQ-015 In STABLE, when sync != db, the FSM SHALL go to CHECK and load the counter with 1.
REQ-016 In CHECK, if sync == db (bounce back), the FSM SHALL return to STABLE and clear the counter, with no change to db and no pulse.
REQ-017 In CHECK, if sync != db and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-018 In CHECK, if sync != db and counter == DEBOUNCE_CYCLES-1, then on that edge the block SHALL: set db <= sync, clear the counter, and return to STABLE.
REQ-019 On the same edge as REQ-018, the block SHALL assert press (if the new pressed is 1) or release (if the new pressed is 0) for exactly one cycle, coincident with the first cycle of the new pressed value.
REQ-020 On the same edge as an accepted press, toggle SHALL invert; a release SHALL leave toggle unchanged.
REQ-021 Total latency SHALL be exactly 2 + DEBOUNCE_CYCLES clock edges from a clean key_in transition to the changed pressed value.
REQ-022 The counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide and SHALL never wrap; it saturates by construction at DEBOUNCE_CYCLES-1.
REQ-023 press and release SHALL never be asserted in the same cycle on the same channel.
REQ-024 Consecutive accepted events on a channel SHALL be at least DEBOUNCE_CYCLES cycles apart.

Reset
REQ-025 While rst is high, the block SHALL force the following values asynchronously: synchronizer flops and db = ACTIVE_LOW (idle level), FSM = STABLE, counter = 0, pressed = 0, press = 0, release = 0, toggle = 0.
REQ-026 Reset asserted mid-CHECK SHALL discard the count, and no pulse SHALL follow deassertion.
REQ-027 If the key is held pressed across reset deassertion, it SHALL be accepted as a new press after 2 + DEBOUNCE_CYCLES cycles, producing one press pulse.

Verification (WIDTH=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
REQ-028 Clean press: key_in[0] goes 1->0 and holds -> pressed[0]=1 and press[0]=1 for one cycle exactly 6 edges later, and toggle[0]=1.
REQ-029 Bounce: key_in[0] low 3 cycles, high 1, then low and held -> no event during the bounce; a single press pulse 6 edges after the final fall.
REQ-030 Release: from pressed, key_in[0] goes 0->1 and holds -> release[0] pulse and pressed[0]=0 after 6 edges, with toggle[0] unchanged.
REQ-031 Two presses on channel 1 with channel 0 idle -> toggle[1] sequence 0->1->0, and channel 0 outputs stay 0 throughout.
REQ-032 Reset mid-CHECK: assert rst 2 cycles into a press -> all outputs 0 immediately; after release of rst with the key still low, one press pulse arrives 6 edges later.

Source files
------------

// File: rtl/key_debouncer.sv
// Multi-channel key/switch debouncer: 2-flop synchronizer, per-channel STABLE/CHECK
// FSM with a saturating stability counter, debounced level plus press/release pulses and toggle.
module key_debouncer #(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key_in,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] toggle
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE = ACTIVE_LOW ? '1 : '0;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] rel_q, rel_d;
    logic [WIDTH-1:0] tog_q, tog_d;
    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CW-1:0]    cnt_q   [WIDTH];
    logic [CW-1:0]    cnt_d   [WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= IDLE;
            sync_q  <= IDLE;
        end else begin
            sync1_q <= key_in;
            sync_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q    <= IDLE;
            press_q <= '0;
            rel_q   <= '0;
            tog_q   <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            db_q    <= db_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            tog_q   <= tog_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        db_d    = db_q;
        press_d = '0;
        rel_d   = '0;
        tog_d   = tog_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                STABLE: begin
                    if (sync_q[i] != db_q[i]) begin
                        state_d[i] = CHECK;
                        cnt_d[i]   = CW'(1);
                    end
                end
                CHECK: begin
                    if (sync_q[i] == db_q[i]) begin
                        state_d[i] = STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        // Accept: pulses are registered alongside db so they align with the new level
                        state_d[i] = STABLE;
                        cnt_d[i]   = '0;
                        db_d[i]    = sync_q[i];
                        if (sync_q[i] ^ ACTIVE_LOW) begin
                            press_d[i] = 1'b1;
                            tog_d[i]   = ~tog_q[i];
                        end else begin
                            rel_d[i] = 1'b1;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    assign pressed       = db_q ^ IDLE;
    assign press         = press_q;
    assign release_pulse = rel_q;
    assign toggle        = tog_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer (WIDTH=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1);
// an accepted change shows up 6 edges after the input transition.
module tb_key_debouncer;

    logic       clk;
    logic       rst;
    logic [1:0] key_in;
    logic [1:0] pressed;
    logic [1:0] press;
    logic [1:0] release_pulse;
    logic [1:0] toggle;

    int checks = 0;
    int errors = 0;

    key_debouncer #(
        .WIDTH          (2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .pressed      (pressed),
        .press        (press),
        .release_pulse(release_pulse),
        .toggle       (toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "timeout");
    end

    // Advance n rising edges, then settle 1 ns so sampling is away from the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_pressed, input logic [1:0] e_press,
                             input logic [1:0] e_rel, input logic [1:0] e_tog);
        check({tag, ".pressed"}, pressed, e_pressed);
        check({tag, ".press"}, press, e_press);
        check({tag, ".release"}, release_pulse, e_rel);
        check({tag, ".toggle"}, toggle, e_tog);
    endtask

    initial begin
        rst    = 1'b1;
        key_in = 2'b11;
        tick(3);
        check_all("reset_hold", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        tick(8);
        check_all("idle", 2'b00, 2'b00, 2'b00, 2'b00);

        // Clean press on channel 0
        key_in[0] = 1'b0;
        tick(5);
        check_all("press0_edge5", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(1);
        check_all("press0_edge6", 2'b01, 2'b01, 2'b00, 2'b01);
        tick(1);
        check_all("press0_edge7", 2'b01, 2'b00, 2'b00, 2'b01);

        // Release on channel 0: toggle unchanged
        key_in[0] = 1'b1;
        tick(5);
        check_all("rel0_edge5", 2'b01, 2'b00, 2'b00, 2'b01);
        tick(1);
        check_all("rel0_edge6", 2'b00, 2'b00, 2'b01, 2'b01);
        tick(1);
        check_all("rel0_edge7", 2'b00, 2'b00, 2'b00, 2'b01);

        // Bounce: low 3, high 1, then low; the glitch lands exactly on the would-be accept edge
        key_in[0] = 1'b0;
        tick(3);
        check_all("bounce_low3", 2'b00, 2'b00, 2'b00, 2'b01);
        key_in[0] = 1'b1;
        tick(1);
        key_in[0] = 1'b0;
        tick(3);
        check_all("bounce_mid", 2'b00, 2'b00, 2'b00, 2'b01);
        tick(2);
        check_all("bounce_edge5", 2'b00, 2'b00, 2'b00, 2'b01);
        tick(1);
        check_all("bounce_edge6", 2'b01, 2'b01, 2'b00, 2'b00);
        tick(1);
        check_all("bounce_edge7", 2'b01, 2'b00, 2'b00, 2'b00);
        key_in[0] = 1'b1;
        tick(6);
        check_all("bounce_rel", 2'b00, 2'b00, 2'b01, 2'b00);
        tick(1);

        // Two presses on channel 1 with channel 0 idle
        key_in[1] = 1'b0;
        tick(6);
        check_all("ch1_press1", 2'b10, 2'b10, 2'b00, 2'b10);
        key_in[1] = 1'b1;
        tick(6);
        check_all("ch1_rel1", 2'b00, 2'b00, 2'b10, 2'b10);
        tick(1);
        key_in[1] = 1'b0;
        tick(6);
        check_all("ch1_press2", 2'b10, 2'b10, 2'b00, 2'b00);
        key_in[1] = 1'b1;
        tick(6);
        check_all("ch1_rel2", 2'b00, 2'b00, 2'b10, 2'b00);
        tick(1);

        // Hold channel 1 pressed so reset has non-zero state to clear
        key_in[1] = 1'b0;
        tick(7);
        check_all("ch1_held", 2'b10, 2'b00, 2'b00, 2'b10);

        // Reset two cycles into a channel 0 check
        key_in[0] = 1'b0;
        tick(4);
        rst = 1'b1;
        #1;
        check_all("rst_mid", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(2);
        check_all("rst_held", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        tick(5);
        check_all("post_rst_edge5", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(1);
        check_all("post_rst_edge6", 2'b11, 2'b11, 2'b00, 2'b11);
        tick(1);
        check_all("post_rst_edge7", 2'b11, 2'b00, 2'b00, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
